// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IEEE 1149.1 TAP state encodings, IR width and the
// TAP next-state function used by both the state register and the pulse decode.
package jtag_pkg;

    localparam int IR_WIDTH = 4;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PA_DR  = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PA_IR  = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TLR;
        case (s)
            TLR:    n = tms ? TLR    : RTI;
            RTI:    n = tms ? SEL_DR : RTI;
            SEL_DR: n = tms ? SEL_IR : CAP_DR;
            CAP_DR: n = tms ? EX1_DR : SH_DR;
            SH_DR:  n = tms ? EX1_DR : SH_DR;
            EX1_DR: n = tms ? UPD_DR : PA_DR;
            PA_DR:  n = tms ? EX2_DR : PA_DR;
            EX2_DR: n = tms ? UPD_DR : SH_DR;
            UPD_DR: n = tms ? SEL_DR : RTI;
            SEL_IR: n = tms ? TLR    : CAP_IR;
            CAP_IR: n = tms ? EX1_IR : SH_IR;
            SH_IR:  n = tms ? EX1_IR : SH_IR;
            EX1_IR: n = tms ? UPD_IR : PA_IR;
            PA_IR:  n = tms ? EX2_IR : PA_IR;
            EX2_IR: n = tms ? UPD_IR : SH_IR;
            UPD_IR: n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    // The IR column of the TAP diagram, SEL_IR through UPD_IR.
    function automatic logic is_ir_side(input tap_state_t s);
        return (s == SEL_IR) || (s == CAP_IR) || (s == SH_IR) || (s == EX1_IR) ||
               (s == PA_IR)  || (s == EX2_IR) || (s == UPD_IR);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register; advances one 1149.1 transition per qualified TCK strobe.
// state_next is exported so the parent can register update pulses on entry.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       ICLK,
    input  logic       reset,
    input  logic       adv,
    input  logic       tms,
    output logic [3:0] state,
    output logic [3:0] state_next
);

    tap_state_t state_reg;
    tap_state_t next_calc;

    assign next_calc = tap_next(state_reg, tms);

    always_ff @(posedge ICLK or negedge reset) begin
        if (!reset) begin
            state_reg <= TLR;
        end else if (adv) begin
            state_reg <= next_calc;
        end
    end

    assign state      = state_reg;
    assign state_next = adv ? next_calc : state_reg;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: output decode, cell strobes and registered update pulses.
// Define JTAG_TAP_IDLE_CNT_EN to add the 16-bit saturating RTI strobe counter idle_cnt.
module jtag_tap_ctrl
    import jtag_pkg::*;
(
    input  logic        ICLK,
    input  logic        reset,
    input  logic        tck_en,
    input  logic        tms,
    output logic        shift_ir,
    output logic        clk_ir,
    output logic        update_ir,
    output logic        shift_dr,
    output logic        clk_dr,
    output logic        update_dr,
    output logic        tlr,
    output logic        tdo_en,
    output logic        tdo_sel,
    output logic [3:0]  tap_state
`ifdef JTAG_TAP_IDLE_CNT_EN
    ,
    output logic [15:0] idle_cnt
`endif
);

    logic       armed_reg;
    logic       adv;
    logic [3:0] state_bits;
    logic [3:0] next_bits;
    tap_state_t state;
    tap_state_t state_next;
    logic       update_ir_reg;
    logic       update_dr_reg;

    // The first cycle after reset release is a settling cycle: strobes are ignored.
    always_ff @(posedge ICLK or negedge reset) begin
        if (!reset) begin
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
        end
    end

    assign adv = tck_en & armed_reg;

    jtag_tap_fsm u_fsm (
        .ICLK       (ICLK),
        .reset      (reset),
        .adv        (adv),
        .tms        (tms),
        .state      (state_bits),
        .state_next (next_bits)
    );

    assign state      = tap_state_t'(state_bits);
    assign state_next = tap_state_t'(next_bits);

    // High exactly in the first cycle spent in UPD_x; never re-fires while parked there.
    always_ff @(posedge ICLK or negedge reset) begin
        if (!reset) begin
            update_ir_reg <= 1'b0;
            update_dr_reg <= 1'b0;
        end else begin
            update_ir_reg <= adv && (state_next == UPD_IR);
            update_dr_reg <= adv && (state_next == UPD_DR);
        end
    end

    // Cell strobes fire on the edge that leaves CAP/SH so the cell samples the
    // mux selection of the state being left.
    assign shift_ir  = (state == SH_IR);
    assign shift_dr  = (state == SH_DR);
    assign clk_ir    = adv && ((state == CAP_IR) || (state == SH_IR));
    assign clk_dr    = adv && ((state == CAP_DR) || (state == SH_DR));
    assign update_ir = update_ir_reg;
    assign update_dr = update_dr_reg;
    assign tlr       = (state == TLR);
    assign tdo_en    = shift_ir || shift_dr;
    assign tdo_sel   = is_ir_side(state);
    assign tap_state = state_bits;

`ifdef JTAG_TAP_IDLE_CNT_EN
    logic [15:0] idle_cnt_reg;

    always_ff @(posedge ICLK or negedge reset) begin
        if (!reset) begin
            idle_cnt_reg <= 16'h0000;
        end else if (adv) begin
            if (state == RTI) begin
                if (idle_cnt_reg != 16'hFFFF) begin
                    idle_cnt_reg <= idle_cnt_reg + 16'h0001;
                end
            end else if (state_next == RTI) begin
                idle_cnt_reg <= 16'h0000;
            end
        end
    end

    assign idle_cnt = idle_cnt_reg;
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IR/DR scans, TLR recovery, strobe hold
// and, when JTAG_TAP_IDLE_CNT_EN is defined, the RTI idle counter.
module tb_jtag_tap_ctrl;

    logic        ICLK;
    logic        reset;
    logic        tck_en;
    logic        tms;
    logic        shift_ir, clk_ir, update_ir;
    logic        shift_dr, clk_dr, update_dr;
    logic        tlr, tdo_en, tdo_sel;
    logic [3:0]  tap_state;
`ifdef JTAG_TAP_IDLE_CNT_EN
    logic [15:0] idle_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters, sampled on the falling edge (mid-cycle).
    int n_clk_ir = 0, n_clk_dr = 0, n_upd_ir = 0, n_upd_dr = 0, n_overlap = 0;

    // Combinational outputs captured during the last strobe cycle.
    logic [3:0] s_state;
    logic       s_clk_ir, s_shift_ir, s_clk_dr, s_shift_dr, s_tdo_en, s_tdo_sel;

    jtag_tap_ctrl dut (
        .ICLK      (ICLK),
        .reset     (reset),
        .tck_en    (tck_en),
        .tms       (tms),
        .shift_ir  (shift_ir),
        .clk_ir    (clk_ir),
        .update_ir (update_ir),
        .shift_dr  (shift_dr),
        .clk_dr    (clk_dr),
        .update_dr (update_dr),
        .tlr       (tlr),
        .tdo_en    (tdo_en),
        .tdo_sel   (tdo_sel),
        .tap_state (tap_state)
`ifdef JTAG_TAP_IDLE_CNT_EN
        ,
        .idle_cnt  (idle_cnt)
`endif
    );

    initial ICLK = 1'b0;
    always #5 ICLK = ~ICLK;

    always @(negedge ICLK) begin
        n_clk_ir = n_clk_ir + int'(clk_ir);
        n_clk_dr = n_clk_dr + int'(clk_dr);
        n_upd_ir = n_upd_ir + int'(update_ir);
        n_upd_dr = n_upd_dr + int'(update_dr);
        if ((clk_ir || update_ir) && (clk_dr || update_dr)) n_overlap = n_overlap + 1;
    end

    // One TCK strobe; called and returns at posedge+1.
    task automatic strobe(input logic v);
        tck_en = 1'b1;
        tms    = v;
        @(negedge ICLK);
        s_state    = tap_state;
        s_clk_ir   = clk_ir;
        s_shift_ir = shift_ir;
        s_clk_dr   = clk_dr;
        s_shift_dr = shift_dr;
        s_tdo_en   = tdo_en;
        s_tdo_sel  = tdo_sel;
        @(posedge ICLK);
        #1;
        tck_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; tck_en = 1'b1; tms = 1'b0;
        repeat (3) @(posedge ICLK);
        #1;
        n_checks++;
        if (tap_state !== 4'hF || tlr !== 1'b1) begin
            n_fail++; $display("FAIL reset_state: got state=%h tlr=%b, expected F/1", tap_state, tlr);
        end
        n_checks++;
        if ({shift_ir, clk_ir, update_ir, shift_dr, clk_dr, update_dr, tdo_en, tdo_sel} !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got %b, expected 00000000",
                {shift_ir, clk_ir, update_ir, shift_dr, clk_dr, update_dr, tdo_en, tdo_sel});
        end
        // Release with tck_en/tms=0 already present: first cycle must be ignored.
        reset = 1'b1;
        @(posedge ICLK); #1;
        n_checks++;
        if (tap_state !== 4'hF) begin
            n_fail++; $display("FAIL release_ignore: got %h, expected F", tap_state);
        end
        @(posedge ICLK); #1;
        n_checks++;
        if (tap_state !== 4'hC) begin
            n_fail++; $display("FAIL release_act: got %h, expected C", tap_state);
        end
        tck_en = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_ir_scan();
        int c_ir, c_dr, u_ir;
        c_ir = n_clk_ir; c_dr = n_clk_dr; u_ir = n_upd_ir;
        strobe(1'b1); strobe(1'b1); strobe(1'b0);
        strobe(1'b0);
        n_checks++;
        if (s_state !== 4'hE || s_clk_ir !== 1'b1 || s_shift_ir !== 1'b0) begin
            n_fail++; $display("FAIL ir_capture: got state=%h clk_ir=%b shift_ir=%b, expected E/1/0",
                s_state, s_clk_ir, s_shift_ir);
        end
        for (int i = 0; i < 4; i++) begin
            strobe(1'b0);
            n_checks++;
            if (s_state !== 4'hA || s_clk_ir !== 1'b1 || s_shift_ir !== 1'b1 ||
                s_tdo_en !== 1'b1 || s_tdo_sel !== 1'b1) begin
                n_fail++; $display("FAIL ir_shift%0d: got state=%h clk=%b sh=%b en=%b sel=%b, expected A/1/1/1/1",
                    i, s_state, s_clk_ir, s_shift_ir, s_tdo_en, s_tdo_sel);
            end
        end
        strobe(1'b1); strobe(1'b1);
        @(negedge ICLK);
        n_checks++;
        if (tap_state !== 4'hD || update_ir !== 1'b1 || update_dr !== 1'b0) begin
            n_fail++; $display("FAIL ir_update: got state=%h upd_ir=%b upd_dr=%b, expected D/1/0",
                tap_state, update_ir, update_dr);
        end
        @(negedge ICLK);
        n_checks++;
        if (update_ir !== 1'b0) begin
            n_fail++; $display("FAIL ir_update_width: got %b, expected 0", update_ir);
        end
        @(posedge ICLK); #1;
        // capture + 4 shifts + exit from SH_IR
        n_checks++;
        if (n_clk_ir - c_ir !== 6 || n_upd_ir - u_ir !== 1 || n_clk_dr - c_dr !== 0) begin
            n_fail++; $display("FAIL ir_counts: got clk_ir=%0d upd_ir=%0d clk_dr=%0d, expected 6/1/0",
                n_clk_ir - c_ir, n_upd_ir - u_ir, n_clk_dr - c_dr);
        end
        strobe(1'b0);
        n_checks++;
        if (tap_state !== 4'hC || tdo_sel !== 1'b0) begin
            n_fail++; $display("FAIL ir_to_rti: got state=%h sel=%b, expected C/0", tap_state, tdo_sel);
        end
        $display("test_ir_scan done");
    endtask

    task automatic test_dr_scan();
        int c_ir, c_dr, u_dr;
        c_ir = n_clk_ir; c_dr = n_clk_dr; u_dr = n_upd_dr;
        strobe(1'b1); strobe(1'b0);
        strobe(1'b0);
        n_checks++;
        if (s_state !== 4'h6 || s_clk_dr !== 1'b1 || s_shift_dr !== 1'b0) begin
            n_fail++; $display("FAIL dr_capture: got state=%h clk_dr=%b shift_dr=%b, expected 6/1/0",
                s_state, s_clk_dr, s_shift_dr);
        end
        for (int i = 0; i < 3; i++) strobe(1'b0);
        n_checks++;
        if (s_shift_dr !== 1'b1 || s_tdo_sel !== 1'b0 || s_tdo_en !== 1'b1) begin
            n_fail++; $display("FAIL dr_shift: got sh=%b sel=%b en=%b, expected 1/0/1",
                s_shift_dr, s_tdo_sel, s_tdo_en);
        end
        strobe(1'b1); strobe(1'b0);
        strobe(1'b1);
        n_checks++;
        if (s_state !== 4'h3 || s_clk_dr !== 1'b0 || s_tdo_en !== 1'b0) begin
            n_fail++; $display("FAIL dr_pause: got state=%h clk_dr=%b tdo_en=%b, expected 3/0/0",
                s_state, s_clk_dr, s_tdo_en);
        end
        strobe(1'b1);
        @(negedge ICLK);
        n_checks++;
        if (tap_state !== 4'h5 || update_dr !== 1'b1 || update_ir !== 1'b0) begin
            n_fail++; $display("FAIL dr_update: got state=%h upd_dr=%b upd_ir=%b, expected 5/1/0",
                tap_state, update_dr, update_ir);
        end
        @(posedge ICLK); #1;
        // capture + 3 shifts + exit from SH_DR; none in PA/EX2
        n_checks++;
        if (n_clk_dr - c_dr !== 5 || n_upd_dr - u_dr !== 1 || n_clk_ir - c_ir !== 0) begin
            n_fail++; $display("FAIL dr_counts: got clk_dr=%0d upd_dr=%0d clk_ir=%0d, expected 5/1/0",
                n_clk_dr - c_dr, n_upd_dr - u_dr, n_clk_ir - c_ir);
        end
        $display("test_dr_scan done");
    endtask

    task automatic test_hold();
        int c_ir, c_dr, u_ir, u_dr;
        c_ir = n_clk_ir; c_dr = n_clk_dr; u_ir = n_upd_ir; u_dr = n_upd_dr;
        tck_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tms = ~tms;
            @(posedge ICLK); #1;
        end
        n_checks++;
        if (tap_state !== 4'h5) begin
            n_fail++; $display("FAIL hold_state: got %h, expected 5", tap_state);
        end
        n_checks++;
        if (n_clk_ir != c_ir || n_clk_dr != c_dr || n_upd_ir != u_ir || n_upd_dr != u_dr) begin
            n_fail++; $display("FAIL hold_pulses: got %0d/%0d/%0d/%0d new pulses, expected 0/0/0/0",
                n_clk_ir - c_ir, n_clk_dr - c_dr, n_upd_ir - u_ir, n_upd_dr - u_dr);
        end
        $display("test_hold done");
    endtask

    task automatic test_tlr_from_rti();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'h7, 4'h4, 4'hF, 4'hF, 4'hF};
        strobe(1'b0);
        for (int i = 0; i < 5; i++) begin
            strobe(1'b1);
            n_checks++;
            if (tap_state !== exp_seq[i]) begin
                n_fail++; $display("FAIL tlr_rti%0d: got %h, expected %h", i, tap_state, exp_seq[i]);
            end
        end
        $display("test_tlr_from_rti done");
    endtask

    task automatic test_tlr_from_shdr();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF};
        strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b0);
        n_checks++;
        if (tap_state !== 4'h2) begin
            n_fail++; $display("FAIL tlr_shdr_start: got %h, expected 2", tap_state);
        end
        for (int i = 0; i < 5; i++) begin
            strobe(1'b1);
            n_checks++;
            if (tap_state !== exp_seq[i] || tlr !== (i == 4)) begin
                n_fail++; $display("FAIL tlr_shdr%0d: got %h tlr=%b, expected %h", i, tap_state, tlr, exp_seq[i]);
            end
        end
        $display("test_tlr_from_shdr done");
    endtask

    task automatic test_reset_shdr();
        strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b0);
        tck_en = 1'b1; tms = 1'b0;
        #1;
        n_checks++;
        if (shift_dr !== 1'b1 || clk_dr !== 1'b1) begin
            n_fail++; $display("FAIL shdr_pre: got shift=%b clk=%b, expected 1/1", shift_dr, clk_dr);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (tap_state !== 4'hF || tlr !== 1'b1 ||
            {shift_dr, clk_dr, update_dr, shift_ir, clk_ir, update_ir, tdo_en} !== 7'h00) begin
            n_fail++; $display("FAIL shdr_reset: got state=%h tlr=%b strobes=%b, expected F/1/0000000",
                tap_state, tlr, {shift_dr, clk_dr, update_dr, shift_ir, clk_ir, update_ir, tdo_en});
        end
        @(posedge ICLK); #1;
        reset = 1'b1; tck_en = 1'b0;
        @(posedge ICLK); #1;
        $display("test_reset_shdr done");
    endtask

    task automatic test_reset_shir();
        int u_ir;
        strobe(1'b0); strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b0);
        tck_en = 1'b1; tms = 1'b1;
        #1;
        n_checks++;
        if (tap_state !== 4'hA || shift_ir !== 1'b1 || clk_ir !== 1'b1) begin
            n_fail++; $display("FAIL shir_pre: got state=%h shift=%b clk=%b, expected A/1/1",
                tap_state, shift_ir, clk_ir);
        end
        u_ir = n_upd_ir;
        reset = 1'b0;
        #1;
        n_checks++;
        if (tap_state !== 4'hF || shift_ir !== 1'b0 || clk_ir !== 1'b0) begin
            n_fail++; $display("FAIL shir_reset: got state=%h shift=%b clk=%b, expected F/0/0",
                tap_state, shift_ir, clk_ir);
        end
        @(posedge ICLK); #1;
        reset = 1'b1; tck_en = 1'b0;
        repeat (3) @(posedge ICLK);
        #1;
        n_checks++;
        if (n_upd_ir != u_ir || tap_state !== 4'hF) begin
            n_fail++; $display("FAIL shir_no_update: got %0d pulses state=%h, expected 0/F",
                n_upd_ir - u_ir, tap_state);
        end
        $display("test_reset_shir done");
    endtask

`ifdef JTAG_TAP_IDLE_CNT_EN
    task automatic test_idle_cnt();
        strobe(1'b0);
        n_checks++;
        if (tap_state !== 4'hC || idle_cnt !== 16'h0000) begin
            n_fail++; $display("FAIL idle_entry: got state=%h cnt=%h, expected C/0000", tap_state, idle_cnt);
        end
        for (int i = 0; i < 3; i++) strobe(1'b0);
        n_checks++;
        if (idle_cnt !== 16'h0003) begin
            n_fail++; $display("FAIL idle_count3: got %h, expected 0003", idle_cnt);
        end
        for (int i = 0; i < 70000; i++) strobe(1'b0);
        n_checks++;
        if (idle_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL idle_saturate: got %h, expected FFFF", idle_cnt);
        end
        strobe(1'b1); strobe(1'b0);
        n_checks++;
        if (tap_state !== 4'h6 || idle_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL idle_hold: got state=%h cnt=%h, expected 6/FFFF", tap_state, idle_cnt);
        end
        strobe(1'b1); strobe(1'b1); strobe(1'b0);
        n_checks++;
        if (tap_state !== 4'hC || idle_cnt !== 16'h0000) begin
            n_fail++; $display("FAIL idle_reentry: got state=%h cnt=%h, expected C/0000", tap_state, idle_cnt);
        end
        $display("test_idle_cnt done");
    endtask
`endif

    task automatic test_no_overlap();
        n_checks++;
        if (n_overlap != 0) begin
            n_fail++; $display("FAIL ir_dr_overlap: got %0d cycles, expected 0", n_overlap);
        end
        $display("test_no_overlap done");
    endtask

    initial begin
        reset = 1'b0; tck_en = 1'b0; tms = 1'b0;
        test_reset();
        test_ir_scan();
        test_dr_scan();
        test_hold();
        test_tlr_from_rti();
        test_tlr_from_shdr();
        test_reset_shdr();
        test_reset_shir();
`ifdef JTAG_TAP_IDLE_CNT_EN
        test_idle_cnt();
`endif
        test_no_overlap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
